// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: segmented-carry pipelined add/subtract unit.
// One SEG-bit carry segment per stage, global stall flow control.
module alu_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c
);

  localparam int NSTG = WIDTH / SEG;
  localparam int L    = NSTG - 1;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_bx     = sub ? ~b : b;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [SEG-1:0]   w_ai;
    logic [SEG-1:0]   w_bi;
    logic [WIDTH-1:0] w_si;
    logic [WIDTH-1:0] w_so;
    logic             w_ci;
    logic             w_ami;
    logic             w_bmi;
    logic             w_sti;
    logic             w_vi;
    logic [SEG:0]     w_seg;

    logic [WIDTH-1:0] r_sum;
    logic             r_cy;
    logic             r_am;
    logic             r_bm;
    logic             r_sat;
    logic             r_vld;

    if (k == 0) begin : g_in
      assign w_ai  = a[SEG-1:0];
      assign w_bi  = w_bx[SEG-1:0];
      assign w_si  = '0;
      assign w_ci  = sub;
      assign w_ami = a[WIDTH-1];
      assign w_bmi = w_bx[WIDTH-1];
      assign w_sti = sat;
      assign w_vi  = in_valid;
    end else begin : g_link
      assign w_ai  = g_stg[k-1].g_fwd.r_a[SEG-1:0];
      assign w_bi  = g_stg[k-1].g_fwd.r_b[SEG-1:0];
      assign w_si  = g_stg[k-1].r_sum;
      assign w_ci  = g_stg[k-1].r_cy;
      assign w_ami = g_stg[k-1].r_am;
      assign w_bmi = g_stg[k-1].r_bm;
      assign w_sti = g_stg[k-1].r_sat;
      assign w_vi  = g_stg[k-1].r_vld;
    end

    assign w_seg = {1'b0, w_ai}
                 + {1'b0, w_bi}
                 + {{SEG{1'b0}}, w_ci};

    // Merge this stage's segment into the partial sum.
    always_comb begin
      w_so = w_si;
      w_so[k*SEG +: SEG] = w_seg[SEG-1:0];
    end

    // Stage register: shifts on advance, holds on stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum <= '0;
        r_cy  <= 1'b0;
        r_am  <= 1'b0;
        r_bm  <= 1'b0;
        r_sat <= 1'b0;
        r_vld <= 1'b0;
      end else if (w_adv) begin
        r_sum <= w_so;
        r_cy  <= w_seg[SEG];
        r_am  <= w_ami;
        r_bm  <= w_bmi;
        r_sat <= w_sti;
        r_vld <= w_vi;
      end
    end

    if (k < L) begin : g_fwd
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] w_ar;
      logic [WIDTH-1:0] w_br;

      if (k == 0) begin : g_src0
        assign w_ar = a;
        assign w_br = w_bx;
      end else begin : g_srcn
        assign w_ar = g_stg[k-1].g_fwd.r_a;
        assign w_br = g_stg[k-1].g_fwd.r_b;
      end

      // Unconsumed operand bits, next segment aligned to bit 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_ar >> SEG;
          r_b <= w_br >> SEG;
        end
      end
    end
  end

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_min;
  logic             w_am;
  logic             w_bm;
  logic             w_ovf;

  assign w_raw = g_stg[L].r_sum;
  assign w_am  = g_stg[L].r_am;
  assign w_bm  = g_stg[L].r_bm;
  assign w_max = {1'b0, {(WIDTH-1){1'b1}}};
  assign w_min = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_ovf = (w_am == w_bm)
              && (w_raw[WIDTH-1] != w_am);

  // Clamp toward the sign of A on signed overflow.
  always_comb begin
    w_res = w_raw;
    if (g_stg[L].r_sat && w_ovf) begin
      w_res = w_am ? w_min : w_max;
    end
  end

  assign out_valid = g_stg[L].r_vld;
  assign s = out_valid ? w_res : '0;
  assign z = out_valid && (w_res == '0);
  assign v = out_valid && w_ovf;
  assign n = out_valid && w_res[WIDTH-1];
  assign c = out_valid && g_stg[L].r_cy;

endmodule

// File: doc/alu_addsub_pipe.md
# alu_addsub_pipe

Parametrised, pipelined add/subtract unit with a full flag set for the CPU datapath. It is the next-generation replacement for the single-cycle ALU adder. The carry chain is split into SEG-bit segments, one pipeline stage per segment, so WIDTH scales without lengthening the critical path. Operands enter and results leave through valid/ready handshakes. The unit adds carry-out and an optional signed-saturation mode.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, bits resolved per pipeline stage; NSTG = WIDTH/SEG stages (NSTG ≥ 1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set on a/b/sub/sat is valid.
- in_ready  output  1  unit accepts an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: S = A+B; 1: S = A−B (computed as A + ~B + 1).
- sat  input  1  1: clamp signed overflow to the signed max/min.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  result.
- z  output  1  s == 0 (after saturation).
- v  output  1  signed overflow of the unsaturated result.
- n  output  1  s[WIDTH-1] (after saturation).
- c  output  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.

## Operation
- An operand set is accepted on a cycle with in_valid && in_ready.
- Stage k (k = 0..NSTG-1) computes segment bits [k·SEG +: SEG] from A, B' = sub ? ~B : B, and the carry registered by stage k−1.
  - Stage 0 carry-in is sub.
- Each stage register holds:
  - the completed lower segments;
  - the unconsumed upper A/B' bits;
  - the carry;
  - the sub and sat flags;
  - a valid bit.
- The final stage forms the full result S_raw and carry c.
  - v = (A[MSB] == B'[MSB]) && (S_raw[MSB] != A[MSB]).
  - If sat && v: s = A[MSB] ? {1,0…0} : {0,1…1}.
  - Otherwise s = S_raw.
  - z and n are derived from the final s; c and v are always derived from the raw arithmetic.
- Flow control is a global stall with no bubble collapsing.
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv = 1, every stage shifts one position. Stage 0 loads the new operand when in_valid && in_ready; otherwise it loads a bubble (valid = 0).
  - When adv = 0, all stage registers hold.
- Data in bubble stages is don't-care, but s/z/v/n/c are driven only from a valid final stage.
- Results emerge in strict acceptance order.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - all stage valid bits and out_valid to 0;
  - s, z, v, n, c to 0;
  - in_ready to 1 immediately.
- Reset asserted mid-operation discards all in-flight operations; no result for them ever appears.
- Latency: an operand accepted at edge t appears with out_valid = 1 after edge t+NSTG−1 (NSTG cycles from acceptance to the output register). For NSTG = 1 it is visible the cycle after acceptance.
- Throughput: one result per cycle while out_ready = 1.
- While out_valid && !out_ready:
  - s/z/v/n/c and out_valid hold stable;
  - in_ready = 0;
  - no operand is lost or duplicated.
- Simultaneous output handshake and input acceptance in the same cycle is legal and required for full throughput.
- The design is fully synchronous apart from reset, with no combinational path from a/b to outputs. in_ready depends combinationally only on out_valid and out_ready.

## Test plan
- Default params; 0x00000001 + 0x00000001, sub = 0 → after 4 cycles: s = 0x00000002, z = 0, v = 0, n = 0, c = 0.
- 0x7FFFFFFF + 0x00000001:
  - sat = 0 → s = 0x80000000, v = 1, n = 1, c = 0.
  - sat = 1 → s = 0x7FFFFFFF, v = 1, n = 0.
- Subtraction cases:
  - 0x00000000 − 0x00000001 → s = 0xFFFFFFFF, c = 0, n = 1, v = 0.
  - 0x12345678 − 0x12345678 → s = 0, z = 1, c = 1.
  - 0x80000000 − 1 with sat = 1 → s = 0x80000000, v = 1.
- Throughput and backpressure:
  - 16 back-to-back random operations, out_ready = 1 → 16 consecutive out_valid cycles, all in order and matching the reference model.
  - Repeat with out_ready toggled pseudo-randomly → no loss, duplication or reordering; outputs stable while stalled.
- Drop rst_n for 1 cycle while 3 operations are in flight → outputs immediately 0, out_valid = 0. None of the 3 results appear afterward; a new operation completes with normal latency.
- WIDTH = 16, SEG = 4 and WIDTH = 8, SEG = 8 (NSTG = 1) configurations → latency NSTG cycles; exhaustive 8-bit add/sub/sat checked against the model for s, z, v, n, c.
